// File: rtl/hazard_control_if.sv
// Decode-side bundle for hazard_control: issue request in, stall/issue/forward selects out.
interface hazard_control_if #(parameter int STALL_CNT_W = 16);
  logic                   dec_valid;
  logic [4:0]             dec_rs1;
  logic [4:0]             dec_rs2;
  logic [4:0]             dec_rd;
  logic                   dec_reg_write;
  logic [1:0]             dec_unit;
  logic                   dec_lane;
  logic                   flush;
  logic [2:0]             hazard_select1;
  logic [2:0]             hazard_select2;
  logic                   stall;
  logic                   issue;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_reg_write, dec_unit, dec_lane, flush,
    input  hazard_select1, hazard_select2, stall, issue, stall_count
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_reg_write, dec_unit, dec_lane, flush,
    output hazard_select1, hazard_select2, stall, issue, stall_count
  );
endinterface

// File: rtl/hazard_control.sv
// Issue hazard control: tracks AU/MUL/LSU in-flight results, WB-port reservations, stall and forwarding.
// Optional macro HAZARD_FWD_EN enables operand forwarding; without it every in-flight match stalls.
module hazard_control #(
  parameter int STALL_CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  hazard_control_if.slave hc
);

  localparam logic [1:0] U_AU = 2'd0, U_MUL = 2'd1, U_LSU = 2'd2, U_NONE = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       lane;
    logic [1:0] unit;
  } stage_t;

  stage_t e1_q, m1_q, m2_q, m3_q, l1_q, l2_q, wb_q;
  stage_t e1_d, m1_d, m2_d, m3_d, l1_d, l2_d, wb_d;
  stage_t new_e;
  logic [4:0]             resv_q, resv_d, resv_set;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]             lat;
  logic                   struct_hz, raw_hz, stall_w, issue_w;
  logic [2:0]             sel1_w, sel2_w;

  function automatic logic [2:0] lat_of(input logic [1:0] u);
    case (u)
      U_AU:    return 3'd2;
      U_MUL:   return 3'd4;
      U_LSU:   return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic hit(input stage_t s, input logic [4:0] rs);
    return s.valid && (rs != 5'd0) && (s.rd == rs);
  endfunction

`ifdef HAZARD_FWD_EN
  // Stage priority, not strict age: E1 > L2 > M3 > WB.
  function automatic logic [2:0] fwd_sel(input logic [4:0] rs, input stage_t e1, input stage_t l2,
                                         input stage_t m3, input stage_t wb);
    if (hit(e1, rs))      return 3'd1 + {2'd0, e1.lane};
    else if (hit(l2, rs)) return 3'd5;
    else if (hit(m3, rs)) return 3'd3 + {2'd0, m3.lane};
    else if (hit(wb, rs)) return 3'd6 + {2'd0, (wb.unit == U_LSU) ? 1'b0 : wb.lane};
    else                  return 3'd0;
  endfunction
`endif

  // Decode-side hazard evaluation, purely combinational.
  always_comb begin
    lat       = lat_of(hc.dec_unit);
    struct_hz = (hc.dec_unit != U_NONE) && resv_q[lat];
`ifdef HAZARD_FWD_EN
    raw_hz = hit(m1_q, hc.dec_rs1) || hit(m2_q, hc.dec_rs1) || hit(l1_q, hc.dec_rs1) ||
             hit(m1_q, hc.dec_rs2) || hit(m2_q, hc.dec_rs2) || hit(l1_q, hc.dec_rs2);
    sel1_w = fwd_sel(hc.dec_rs1, e1_q, l2_q, m3_q, wb_q);
    sel2_w = fwd_sel(hc.dec_rs2, e1_q, l2_q, m3_q, wb_q);
`else
    raw_hz = hit(e1_q, hc.dec_rs1) || hit(m1_q, hc.dec_rs1) || hit(m2_q, hc.dec_rs1) ||
             hit(m3_q, hc.dec_rs1) || hit(l1_q, hc.dec_rs1) || hit(l2_q, hc.dec_rs1) ||
             hit(wb_q, hc.dec_rs1) ||
             hit(e1_q, hc.dec_rs2) || hit(m1_q, hc.dec_rs2) || hit(m2_q, hc.dec_rs2) ||
             hit(m3_q, hc.dec_rs2) || hit(l1_q, hc.dec_rs2) || hit(l2_q, hc.dec_rs2) ||
             hit(wb_q, hc.dec_rs2);
    sel1_w = 3'd0;
    sel2_w = 3'd0;
`endif
    stall_w = hc.dec_valid && (struct_hz || raw_hz);
    issue_w = hc.dec_valid && !stall_w && !hc.flush;
  end

  assign hc.stall          = stall_w;
  assign hc.issue          = issue_w;
  assign hc.hazard_select1 = sel1_w;
  assign hc.hazard_select2 = sel2_w;
  assign hc.stall_count    = cnt_q;

  always_comb begin
    new_e       = '0;
    new_e.valid = issue_w && hc.dec_reg_write && (hc.dec_rd != 5'd0) && (hc.dec_unit != U_NONE);
    new_e.rd    = hc.dec_rd;
    new_e.lane  = hc.dec_lane;
    new_e.unit  = hc.dec_unit;

    e1_d = '0;
    m1_d = '0;
    l1_d = '0;
    case (hc.dec_unit)
      U_AU:    e1_d = new_e;
      U_MUL:   m1_d = new_e;
      U_LSU:   l1_d = new_e;
      default: ;
    endcase
    m2_d = m1_q;
    m3_d = m2_q;
    l2_d = l1_q;

    // Reservations guarantee at most one of these reaches WB in a given cycle.
    wb_d = '0;
    if (e1_q.valid)      wb_d = e1_q;
    else if (m3_q.valid) wb_d = m3_q;
    else if (l2_q.valid) wb_d = l2_q;

    resv_set = (issue_w && hc.dec_unit != U_NONE) ? (5'd1 << lat) : 5'd0;
    resv_d   = (resv_q | resv_set) >> 1;

    // Flush kills everything still speculative; the current WB occupant retires this cycle.
    if (hc.flush) begin
      e1_d   = '0;
      m1_d   = '0;
      m2_d   = '0;
      m3_d   = '0;
      l1_d   = '0;
      l2_d   = '0;
      wb_d   = '0;
      resv_d = '0;
    end

    cnt_d = cnt_q;
    if (stall_w && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e1_q   <= '0;
      m1_q   <= '0;
      m2_q   <= '0;
      m3_q   <= '0;
      l1_q   <= '0;
      l2_q   <= '0;
      wb_q   <= '0;
      resv_q <= '0;
      cnt_q  <= '0;
    end else begin
      e1_q   <= e1_d;
      m1_q   <= m1_d;
      m2_q   <= m2_d;
      m3_q   <= m3_d;
      l1_q   <= l1_d;
      l2_q   <= l2_d;
      wb_q   <= wb_d;
      resv_q <= resv_d;
      cnt_q  <= cnt_d;
    end
  end

  logic unused_state;
  assign unused_state = ^{e1_q, m1_q, m2_q, m3_q, l1_q, l2_q, wb_q, resv_q};

endmodule

// File: tb/tb_hazard_control.sv
// Randomized + directed bench for hazard_control against an in-flight-operation list model.
module tb_hazard_control;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hazard_control_if #(.STALL_CNT_W(W)) hif();
  hazard_control #(.STALL_CNT_W(W)) dut (.clk(clk), .reset_n(reset_n), .hc(hif));

  typedef struct {
    logic [4:0] rd;
    int         unit;
    logic       lane;
    bit         wr;
    int         age;
  } op_t;

  op_t ops[$];
  int  mcnt;
  int  n_chk = 0;
  int  n_err = 0;
  bit  e_stall, e_issue;
  int  e_sel1, e_sel2;
  logic        o_stall, o_issue;
  logic [2:0]  o_sel1, o_sel2;
  logic [W-1:0] o_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : (u == 1) ? 4 : 3;
  endfunction

  // Forwarding source for rs: rank by stage priority E1, L2, M3, WB.
  function automatic int fwd_code(input logic [4:0] rs);
    int best = 4, code = 0, rank, c;
    if (rs == 0) return 0;
    foreach (ops[i]) begin
      if (!ops[i].wr || ops[i].rd != rs) continue;
      if (ops[i].unit == 0 && ops[i].age == 1)      begin rank = 0; c = 1 + ops[i].lane; end
      else if (ops[i].unit == 2 && ops[i].age == 2) begin rank = 1; c = 5; end
      else if (ops[i].unit == 1 && ops[i].age == 3) begin rank = 2; c = 3 + ops[i].lane; end
      else if (ops[i].age == lat_of(ops[i].unit))
        begin rank = 3; c = 6 + ((ops[i].unit == 2) ? 0 : ops[i].lane); end
      else continue;
      if (rank < best) begin best = rank; code = c; end
    end
    return code;
  endfunction

  function automatic bit raw_busy(input logic [4:0] rs);
    if (rs == 0) return 0;
    foreach (ops[i]) begin
      if (!ops[i].wr || ops[i].rd != rs) continue;
`ifdef HAZARD_FWD_EN
      if ((ops[i].unit == 1 && ops[i].age <= 2) || (ops[i].unit == 2 && ops[i].age == 1)) return 1;
`else
      return 1;
`endif
    end
    return 0;
  endfunction

  // One clock: drive at negedge, check mid-cycle, advance the model at posedge.
  task automatic cyc(input bit v, input int u, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input bit rw, input bit ln, input bit fl, input bit rn);
    bit st;
    @(negedge clk);
    hif.dec_valid = v; hif.dec_unit = u[1:0]; hif.dec_rs1 = rs1; hif.dec_rs2 = rs2;
    hif.dec_rd = rd; hif.dec_reg_write = rw; hif.dec_lane = ln; hif.flush = fl; reset_n = rn;
    #1;
    st = 0;
    if (u != 3)
      foreach (ops[i]) if (lat_of(ops[i].unit) - ops[i].age == lat_of(u)) st = 1;
    if (raw_busy(rs1) || raw_busy(rs2)) st = 1;
    e_stall = v && st;
    e_issue = v && !e_stall && !fl;
`ifdef HAZARD_FWD_EN
    e_sel1 = fwd_code(rs1);
    e_sel2 = fwd_code(rs2);
`else
    e_sel1 = 0;
    e_sel2 = 0;
`endif
    o_stall = hif.stall; o_issue = hif.issue; o_sel1 = hif.hazard_select1;
    o_sel2 = hif.hazard_select2; o_cnt = hif.stall_count;
    chk("stall", o_stall, e_stall);
    chk("issue", o_issue, e_issue);
    chk("sel1", o_sel1, e_sel1);
    chk("sel2", o_sel2, e_sel2);
    chk("stall_count", o_cnt, mcnt);
    @(posedge clk);
    if (!rn) begin
      ops.delete();
      mcnt = 0;
    end else begin
      if (e_stall && mcnt < (1 << W) - 1) mcnt++;
      if (fl) ops.delete();
      else begin
        foreach (ops[i]) ops[i].age++;
        for (int i = ops.size() - 1; i >= 0; i--)
          if (ops[i].age > lat_of(ops[i].unit)) ops.delete(i);
        if (e_issue && u != 3) ops.push_back('{rd, u, ln, (rw && rd != 0), 1});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 3, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    cyc(0, 3, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int nst;
    mcnt = 0;
    hif.dec_valid = 0; hif.dec_unit = 2'd3; hif.dec_rs1 = 0; hif.dec_rs2 = 0;
    hif.dec_rd = 0; hif.dec_reg_write = 0; hif.dec_lane = 0; hif.flush = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);

    // Post-reset idle outputs
    idle(1);
    chk("rst_stall", o_stall, 0);
    chk("rst_issue", o_issue, 0);
    chk("rst_sel", {o_sel1, o_sel2}, 0);
    chk("rst_cnt", o_cnt, 0);

    // AU rd=5 then consumer of r5
    cyc(1, 0, 0, 0, 5, 1, 1, 0, 1);
    cyc(1, 3, 5, 0, 0, 0, 0, 0, 1);
`ifdef HAZARD_FWD_EN
    chk("au_fwd_stall", o_stall, 0);
    chk("au_fwd_sel1", o_sel1, 2);
`else
    chk("au_nofwd_stall", o_stall, 1);
`endif
    idle(5);

    // MUL rd=7 lane1, consumer waits
    do_reset();
    cyc(1, 1, 0, 0, 7, 1, 1, 0, 1);
    nst = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 3, 0, 7, 0, 0, 0, 0, 1);
      if (o_issue === 1'b1) break;
      if (o_stall === 1'b1) nst++;
    end
    chk("mul_issued", o_issue, 1);
`ifdef HAZARD_FWD_EN
    chk("mul_stalls", nst, 2);
    chk("mul_sel2", o_sel2, 4);
    idle(1);
    chk("mul_cnt", o_cnt, 2);
`else
    chk("mul_stalls", nst, 4);
    idle(1);
    chk("mul_cnt", o_cnt, 4);
`endif
    idle(5);

    // WB port: MUL then AU fits; MUL then LSU collides once
    do_reset();
    cyc(1, 1, 0, 0, 1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 2, 1, 0, 0, 1);
    chk("au_after_mul_stall", o_stall, 0);
    chk("au_after_mul_issue", o_issue, 1);
    idle(5);
    cyc(1, 1, 0, 0, 1, 1, 0, 0, 1);
    cyc(1, 2, 0, 0, 4, 1, 0, 0, 1);
    chk("lsu_collide_stall", o_stall, 1);
    cyc(1, 2, 0, 0, 4, 1, 0, 0, 1);
    chk("lsu_retry_issue", o_issue, 1);
    idle(5);

    // Flush kills LSU in L1
    do_reset();
    cyc(1, 2, 0, 0, 3, 1, 0, 0, 1);
    cyc(0, 3, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 3, 3, 0, 0, 0, 0, 0, 1);
    chk("flush_stall", o_stall, 0);
    chk("flush_sel1", o_sel1, 0);

    // rd=0 never tracked; reset mid-MUL
    do_reset();
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(1, 3, 0, 0, 0, 0, 0, 0, 1);
    chk("r0_stall", o_stall, 0);
    chk("r0_sel", {o_sel1, o_sel2}, 0);
    cyc(1, 1, 0, 0, 9, 1, 1, 0, 1);
    cyc(0, 3, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 3, 9, 9, 0, 0, 0, 0, 1);
    chk("rstmid_stall", o_stall, 0);
    chk("rstmid_issue", o_issue, 0);
    chk("rstmid_sel", {o_sel1, o_sel2}, 0);
    chk("rstmid_cnt", o_cnt, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 3),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 4) != 0), $urandom_range(0, 1),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
